// File: rtl/coder_symbol_mapper.sv
// coder_symbol_mapper
//   Serialises coded bytes MSB-first into BPSK / QPSK / 16-QAM constellation
//   points for the OFDM subcarrier loader. One symbol is presented per cycle
//   while the downstream is ready, and the next byte can be accepted in the
//   same cycle that the last symbol of the current byte is consumed, so
//   back-to-back bytes produce a gap-free symbol stream.
//
// Parameters
//   IQ_W  width of the signed I/Q outputs
//   UNIT  base amplitude; levels are +/-UNIT and +/-3*UNIT
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0=BPSK, 1=QPSK, 2=16-QAM, 3=QPSK; sampled on byte acceptance
//   in_data    coded byte
//   in_valid   in_data valid
//   in_ready   byte accepted this cycle when in_valid is also high
//   out_i      signed in-phase value (registered)
//   out_q      signed quadrature value (registered)
//   out_valid  out_i/out_q/out_last valid
//   out_ready  downstream accepts the current symbol
//   out_last   current symbol is the last one of its byte
module coder_symbol_mapper #(
  parameter int IQ_W = 16,
  parameter int UNIT = 2000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic signed [IQ_W-1:0] out_i,
  output logic signed [IQ_W-1:0] out_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  // The largest level must be representable without overflow.
  if (64'(3) * 64'(UNIT) >= (64'(1) << (IQ_W - 1))) begin : g_unit_check
    $error("coder_symbol_mapper: 3*UNIT does not fit in IQ_W signed bits");
  end

  typedef enum logic {
    ST_EMPTY,
    ST_EMIT
  } state_t;

  typedef enum logic [1:0] {
    M_BPSK  = 2'd0,
    M_QPSK  = 2'd1,
    M_QAM16 = 2'd2,
    M_RSVD  = 2'd3
  } mode_t;

  localparam logic signed [IQ_W-1:0] LVL_P1 = IQ_W'(UNIT);
  localparam logic signed [IQ_W-1:0] LVL_N1 = IQ_W'(-UNIT);
  localparam logic signed [IQ_W-1:0] LVL_P3 = IQ_W'(3 * UNIT);
  localparam logic signed [IQ_W-1:0] LVL_N3 = IQ_W'(-3 * UNIT);

  // Reserved mode behaves as QPSK.
  function automatic mode_t norm_mode(input logic [1:0] m);
    mode_t r;
    r = mode_t'(m);
    if (r == M_RSVD) r = M_QPSK;
    return r;
  endfunction

  // Symbols still to be emitted after the first one of a byte.
  function automatic logic [2:0] remaining_after_first(input mode_t m);
    logic [2:0] r;
    case (m)
      M_BPSK:  r = 3'd7;
      M_QAM16: r = 3'd1;
      default: r = 3'd3;
    endcase
    return r;
  endfunction

  // Discard the k bits that were just mapped.
  function automatic logic [7:0] drop_symbol(input logic [7:0] v, input mode_t m);
    logic [7:0] r;
    case (m)
      M_BPSK:  r = {v[6:0], 1'b0};
      M_QAM16: r = {v[3:0], 4'b0000};
      default: r = {v[5:0], 2'b00};
    endcase
    return r;
  endfunction

  // Binary bit to antipodal level: 0 -> +UNIT, 1 -> -UNIT.
  function automatic logic signed [IQ_W-1:0] antipodal(input logic b);
    return b ? LVL_N1 : LVL_P1;
  endfunction

  // Gray-coded 4-level axis: 00 -3U, 01 -U, 11 +U, 10 +3U.
  function automatic logic signed [IQ_W-1:0] gray4(input logic [1:0] b);
    logic signed [IQ_W-1:0] r;
    case (b)
      2'b00:   r = LVL_N3;
      2'b01:   r = LVL_N1;
      2'b11:   r = LVL_P1;
      default: r = LVL_P3;
    endcase
    return r;
  endfunction

  state_t                 state;
  state_t                 state_nxt;
  mode_t                  mode_q;
  logic [7:0]             shreg;
  logic [2:0]             sym_cnt;

  logic                   accept;
  logic                   advance;
  mode_t                  src_mode;
  logic [3:0]             src_bits;
  logic signed [IQ_W-1:0] sym_i;
  logic signed [IQ_W-1:0] sym_q;

  // Handshake and output-valid decode.
  always_comb begin
    out_valid = (state == ST_EMIT);
    in_ready  = !out_valid || (out_ready && out_last);
    accept    = in_valid && in_ready;
    advance   = out_valid && out_ready;
  end

  // A fresh byte is mapped straight from the input so its first symbol
  // appears one cycle after acceptance; otherwise the shift register feeds
  // the mapper with the latched mode.
  always_comb begin
    src_mode = mode_q;
    src_bits = shreg[7:4];
    if (accept) begin
      src_mode = norm_mode(mode);
      src_bits = in_data[7:4];
    end
  end

  always_comb begin
    sym_i = '0;
    sym_q = '0;
    case (src_mode)
      M_BPSK: begin
        sym_i = antipodal(src_bits[3]);
      end
      M_QAM16: begin
        sym_i = gray4(src_bits[3:2]);
        sym_q = gray4(src_bits[1:0]);
      end
      default: begin
        sym_i = antipodal(src_bits[3]);
        sym_q = antipodal(src_bits[2]);
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (accept) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (advance && out_last) state_nxt = accept ? ST_EMIT : ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Symbol datapath. Acceptance has priority: it can only coincide with an
  // advance when the last symbol is being consumed, and then the new byte
  // replaces it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= M_QPSK;
      shreg    <= '0;
      sym_cnt  <= '0;
      out_i    <= '0;
      out_q    <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      mode_q   <= src_mode;
      shreg    <= drop_symbol(in_data, src_mode);
      sym_cnt  <= remaining_after_first(src_mode);
      out_i    <= sym_i;
      out_q    <= sym_q;
      out_last <= 1'b0;
    end else if (advance) begin
      if (out_last) begin
        out_last <= 1'b0;
      end else begin
        shreg    <= drop_symbol(shreg, mode_q);
        sym_cnt  <= sym_cnt - 3'd1;
        out_i    <= sym_i;
        out_q    <= sym_q;
        out_last <= (sym_cnt == 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_coder_symbol_mapper.sv
module tb_coder_symbol_mapper;

  localparam int IQ_W = 16;
  localparam int UNIT = 2000;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             mode;
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IQ_W-1:0] out_i;
  logic signed [IQ_W-1:0] out_q;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  always #5 clk = ~clk;

  coder_symbol_mapper #(.IQ_W(IQ_W), .UNIT(UNIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  typedef struct {int i; int q; bit last;} sym_t;
  typedef struct {int i; int q; bit last; int cyc;} got_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  sym_t exp_q[$];
  sym_t scratch[$];
  got_t got[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int gray(input int v);
    case (v)
      0:       return -3 * UNIT;
      1:       return -UNIT;
      3:       return UNIT;
      default: return 3 * UNIT;
    endcase
  endfunction

  // Reference: expand one byte into its symbol list from the mapping rules.
  function automatic void gen(input int m, input int b);
    int k;
    int n;
    scratch.delete();
    k = (m == 0) ? 1 : (m == 2) ? 4 : 2;
    n = 8 / k;
    for (int s = 0; s < n; s++) begin
      sym_t x;
      int   v;
      v = (b >> (8 - k * (s + 1))) & ((1 << k) - 1);
      if (k == 1) begin
        x.i = (v != 0) ? -UNIT : UNIT;
        x.q = 0;
      end else if (k == 2) begin
        x.i = ((v >> 1) != 0) ? -UNIT : UNIT;
        x.q = ((v & 1) != 0) ? -UNIT : UNIT;
      end else begin
        x.i = gray(v >> 2);
        x.q = gray(v & 3);
      end
      x.last = (s == n - 1);
      scratch.push_back(x);
    end
  endfunction

  function automatic void push_byte(input int m, input int b);
    gen(m, b);
    foreach (scratch[j]) exp_q.push_back(scratch[j]);
  endfunction

  // Compare process: outputs and in_ready are stable at the falling edge,
  // and the handshakes seen here are the ones the next rising edge commits.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, (exp_q.size() == 0) || (out_ready && exp_q.size() == 1));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_i", out_i, exp_q[0].i);
        chk("out_q", out_q, exp_q[0].q);
        chk("out_last", out_last, exp_q[0].last);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        got.push_back('{int'(out_i), int'(out_q), out_last, cyc});
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) push_byte(int'(mode), int'(in_data));
    end
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [1:0] m, input logic [7:0] d);
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    bit ok = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sym(input string nm, input int idx, input int ei, input int eq, input bit el);
    if (idx < got.size()) begin
      chk({nm, "_i"}, got[idx].i, ei);
      chk({nm, "_q"}, got[idx].q, eq);
      chk({nm, "_last"}, got[idx].last, el);
    end else begin
      chk({nm, "_missing"}, got.size(), idx + 1);
    end
  endtask

  task automatic check_contig(input string nm);
    for (int j = 1; j < got.size(); j++) chk(nm, got[j].cyc - got[0].cyc, j);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    mode      = 2'd1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Pin the reference model to hand-derived values.
    gen(1, 'hB4);
    chk("model_qpsk_len", scratch.size(), 4);
    chk("model_qpsk_i0", scratch[0].i, -2000);
    chk("model_qpsk_q0", scratch[0].q, 2000);
    chk("model_qpsk_q2", scratch[2].q, -2000);
    chk("model_qpsk_last3", scratch[3].last, 1);
    gen(2, 'h3C);
    chk("model_qam_i0", scratch[0].i, -6000);
    chk("model_qam_q1", scratch[1].q, -6000);
    gen(2, 'hA5);
    chk("model_qam_a5_i0", scratch[0].i, 6000);
    chk("model_qam_a5_q1", scratch[1].q, -2000);
    gen(0, 'h81);
    chk("model_bpsk_len", scratch.size(), 8);
    chk("model_bpsk_i7", scratch[7].i, -2000);
    chk("model_bpsk_i3", scratch[3].i, 2000);

    // Reset state.
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // QPSK 0xB4.
    out_ready = 1'b1;
    got.delete();
    send_byte(2'd1, 8'hB4);
    chk("qpsk_latency", got.size(), 0);
    drain();
    chk("qpsk_count", got.size(), 4);
    expect_sym("qpsk_s1", 0, -2000, 2000, 0);
    expect_sym("qpsk_s2", 1, -2000, -2000, 0);
    expect_sym("qpsk_s3", 2, 2000, -2000, 0);
    expect_sym("qpsk_s4", 3, 2000, 2000, 1);
    if (got.size() > 0) chk("qpsk_first_cyc", got[0].cyc, acc_cyc + 1);
    check_contig("qpsk_contig");

    // 16-QAM 0x3C then 0xA5, back to back.
    got.delete();
    send_byte(2'd2, 8'h3C);
    send_byte(2'd2, 8'hA5);
    drain();
    chk("qam_count", got.size(), 4);
    expect_sym("qam_s1", 0, -6000, 2000, 0);
    expect_sym("qam_s2", 1, 2000, -6000, 1);
    expect_sym("qam_s3", 2, 6000, 6000, 0);
    expect_sym("qam_s4", 3, -2000, -2000, 1);
    check_contig("qam_contig");

    // BPSK 0x81.
    got.delete();
    send_byte(2'd0, 8'h81);
    drain();
    chk("bpsk_count", got.size(), 8);
    for (int j = 0; j < 8; j++)
      expect_sym($sformatf("bpsk_s%0d", j + 1), j, (j == 0 || j == 7) ? -2000 : 2000, 0, j == 7);

    // Backpressure on symbol 2.
    got.delete();
    send_byte(2'd1, 8'hB4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_i", out_i, -2000);
      chk("stall_q", out_q, -2000);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    drain();
    chk("stall_count", got.size(), 4);
    expect_sym("stall_s2", 1, -2000, -2000, 0);
    expect_sym("stall_s3", 2, 2000, -2000, 0);
    expect_sym("stall_s4", 3, 2000, 2000, 1);

    // Throughput and mode latch.
    got.delete();
    send_byte(2'd1, 8'h00);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    mode     = 2'd2;
    @(posedge clk);
    #1;
    mode = 2'd1;
    wait_accept();
    drain();
    chk("thru_count", got.size(), 8);
    for (int j = 0; j < 8; j++)
      expect_sym($sformatf("thru_s%0d", j + 1), j, (j < 4) ? 2000 : -2000, (j < 4) ? 2000 : -2000, j == 3 || j == 7);
    check_contig("thru_contig");
    if (got.size() > 3) chk("thru_ready_on_last", acc_cyc, got[3].cyc);

    // Asynchronous reset while symbol 2 is pending.
    got.delete();
    send_byte(2'd1, 8'hB4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_i", out_i, 0);
    chk("arst_out_q", out_q, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    got.delete();
    send_byte(2'd1, 8'h00);
    drain();
    chk("arst_count", got.size(), 4);
    for (int j = 0; j < 4; j++)
      expect_sym($sformatf("arst_s%0d", j + 1), j, 2000, 2000, j == 3);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    chk("random_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coder_symbol_mapper.md
Name: coder_symbol_mapper

Overview:
- Consumes the 8-bit coded byte stream from the channel coder stage and turns it into complex constellation points (I/Q) for the OFDM subcarrier loader.
- Serialises each byte MSB-first into BPSK, QPSK or 16-QAM symbols.
- Uses valid/ready handshakes on both sides, with a registered output and full throughput (no bubble between bytes).

Parameters:
- IQ_W, 16, width of signed I and Q outputs.
- UNIT, 2000, base amplitude; constellation levels are ±UNIT and ±3·UNIT; 3·UNIT must fit in IQ_W signed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  0=BPSK, 1=QPSK, 2=16-QAM, 3=reserved (treated as QPSK); sampled only on byte acceptance.
- in_data  input  8  coded byte from the coder.
- in_valid  input  1  in_data valid.
- in_ready  output  1  mapper accepts in_data this cycle.
- out_i  output  IQ_W  signed in-phase value.
- out_q  output  IQ_W  signed quadrature value.
- out_valid  output  1  out_i/out_q/out_last valid.
- out_ready  input  1  downstream accepts the symbol.
- out_last  output  1  symbol is the last one of its byte.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_i=0, out_q=0, out_last=0, symbol counter=0, shift register=0, latched mode=QPSK. in_ready=1 after reset.
- Bits per symbol k: BPSK 1, QPSK 2, 16-QAM 4. Symbols per byte are 8/k: 8, 4 or 2.
- Byte accept: occurs when in_valid && in_ready.
  - The mapper latches mode.
  - It loads the byte into the shift register.
  - It registers the first symbol (top k bits) into out_i/out_q with out_valid=1 the next cycle (latency 1).
- Symbol advance: occurs when out_valid && out_ready.
  - The shift register moves left by k and the counter decrements.
  - The next symbol is registered.
  - After the last symbol, out_valid drops unless a new byte is accepted in the same cycle.
- in_ready = !out_valid || (out_ready && out_last), combinational. Back-to-back bytes therefore give continuous out_valid with no gap.
- Stall (out_valid && !out_ready): out_i, out_q and out_last hold stable. in_ready=0 (unless the held symbol is last and out_ready=1, which is not a stall).
- States:
  - EMPTY (out_valid=0): on accept, go to EMIT.
  - EMIT: on a consumed last symbol, go to EMPTY, or stay in EMIT if a byte is accepted in the same cycle.
- Mapping (0 maps to positive for BPSK/QPSK):
  - BPSK: bit 0 gives I=+UNIT, bit 1 gives I=-UNIT; Q=0.
  - QPSK: bits b1b0 with I from b1, Q from b0; 0 gives +UNIT, 1 gives -UNIT.
  - 16-QAM: bits b3b2b1b0 with I from b3b2, Q from b1b0. Gray mapping: 00 gives -3U, 01 gives -U, 11 gives +U, 10 gives +3U.
- out_last=1 exactly on symbol 8/k of each byte.
- A mode change mid-byte has no effect until the next byte accept.
- Arithmetic: levels are constants sign-extended to IQ_W. There is no saturation logic; a parameter check enforces 3·UNIT < 2^(IQ_W-1).
- Reset mid-byte: the partial byte is discarded and no further symbols are emitted for it. After release, the next accepted byte starts fresh.
- in_valid low while in EMIT: no effect. Emission of the held byte continues.

Test Plan:
- Reset, then mode=1, in_data=0xB4 accepted with out_ready=1:
  - 4 symbols on consecutive cycles starting 1 cycle after accept.
  - (I,Q) = (-2000,+2000), (-2000,-2000), (+2000,-2000), (+2000,+2000).
  - out_last only on the 4th symbol.
- mode=2, in_data=0x3C:
  - Symbol 1 = (-6000,+2000); symbol 2 = (+2000,-6000), with out_last=1.
  - A third accepted byte 0xA5 yields (+6000,+6000), (-2000,-2000).
- mode=0, in_data=0x81: I sequence is -2000, +2000×6, -2000, with Q=0 throughout and out_last on the 8th symbol.
- Backpressure:
  - QPSK byte 0xB4 with out_ready low for 3 cycles on symbol 2: out_i=-2000 and out_q=-2000 held, in_ready=0.
  - Resume: remaining symbols are correct and no symbol is dropped or duplicated.
- Throughput and mode latch: two QPSK bytes 0x00, 0xFF presented continuously with out_ready=1.
  - 8 consecutive out_valid cycles: 4×(+2000,+2000) then 4×(-2000,-2000).
  - in_ready=1 in the cycle the 4th symbol is consumed.
  - mode switched to 2 during byte 1 does not alter byte 1.
- Assert rst_n low while symbol 2 of a QPSK byte is pending:
  - out_valid=0 and out_i=out_q=0 immediately (asynchronous).
  - After release, a new byte 0x00 gives exactly 4 symbols of (+2000,+2000).
